// File: rtl/mem_io_responder_pkg.sv
// rtl/mem_io_responder_pkg.sv - shared I/O page addresses and stop FSM states for mem_io_responder
package mem_io_responder_pkg;

  localparam logic [1:0]  IO_PAGE = 2'b11;
  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [17:0] IO_CLK  = 18'h30004;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_NUL    = 2'd2,
    ST_HALTED = 2'd3
  } stop_state_t;

  function automatic logic is_io_addr(input logic [17:0] a);
    return a[17:16] == IO_PAGE;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// rtl/mem_io_responder_if.sv - cpu memory bus between the cpu and mem_io_responder
interface mem_io_responder_if;

  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (output mem_a, mem_dout, mem_wr, input mem_din, io_buffer_full);
  modport slave  (input mem_a, mem_dout, mem_wr, output mem_din, io_buffer_full);

endinterface

// File: rtl/mem_io_responder_sync_byte_fifo.sv
// rtl/mem_io_responder_sync_byte_fifo.sv - synchronous byte FIFO; a push to a full FIFO succeeds only alongside a pop
module mem_io_responder_sync_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - cpu-bus responder: byte RAM, I/O page, UART TX FIFO, cycle counter, stop FSM
// Optional feature macro: MEM_IO_RX_EN (UART RX FIFO behind the 0x30000 read).
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_DEPTH  = 8,
  parameter int RX_FIFO_DEPTH  = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  mem_io_responder_if.slave bus,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              halted,
  output logic              tx_overflow
);

  localparam int TX_CW = $clog2(TX_FIFO_DEPTH) + 1;

  logic [7:0]       ram [2**RAM_ADDR_WIDTH];
  logic [17:0]      a;
  logic             io_sel, running, wr_en, rd_en, tx_push, stop_req, ram_we, rx_rd;
  stop_state_t      state_q, state_d;
  logic [31:0]      cycle_cnt, snapshot;
  logic [7:0]       rd_byte, rx_byte, tx_head;
  logic             tx_full, tx_empty, tx_pop_acc, tx_push_acc;
  logic [TX_CW-1:0] tx_count, tx_count_nxt;
  logic             unused_bus;

  assign a          = bus.mem_a[17:0];
  assign io_sel     = is_io_addr(a);
  assign running    = (state_q == ST_RUN);
  assign wr_en      = bus.mem_wr && running;
  assign rd_en      = !bus.mem_wr;
  assign tx_push    = wr_en && (a == IO_BASE) && (bus.mem_dout != 8'h00);
  assign stop_req   = wr_en && (a == IO_CLK);
  assign ram_we     = wr_en && !io_sel;
  assign rx_rd      = rd_en && (a == IO_BASE);
  assign halted     = (state_q == ST_HALTED);
  assign unused_bus = ^bus.mem_a[31:18];

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[bus.mem_a[RAM_ADDR_WIDTH-1:0]] <= bus.mem_dout;
  end

  always_comb begin
    rd_byte = 8'h00;
    if (!io_sel) begin
      rd_byte = ram[bus.mem_a[RAM_ADDR_WIDTH-1:0]];
    end else begin
      case (a)
        IO_BASE:        rd_byte = rx_byte;
        IO_CLK:         rd_byte = cycle_cnt[7:0];
        IO_CLK + 18'd1: rd_byte = snapshot[15:8];
        IO_CLK + 18'd2: rd_byte = snapshot[23:16];
        IO_CLK + 18'd3: rd_byte = snapshot[31:24];
        default:        rd_byte = 8'h00;
      endcase
    end
  end

  // Next-cycle occupancy gives the cpu two writes of slack before the FIFO is truly full.
  assign tx_pop_acc   = tx_ready && !tx_empty;
  assign tx_push_acc  = tx_push && (!tx_full || tx_pop_acc);
  assign tx_count_nxt = tx_count + TX_CW'(tx_push_acc) - TX_CW'(tx_pop_acc);

  mem_io_responder_sync_byte_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (tx_push),
    .pop   (tx_ready),
    .din   (bus.mem_dout),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

`ifdef MEM_IO_RX_EN
  logic                           rx_full, rx_empty;
  logic [$clog2(RX_FIFO_DEPTH):0] rx_count;
  logic [7:0]                     rx_head;
  logic                           unused_rx;

  mem_io_responder_sync_byte_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (rx_valid),
    .pop   (rx_rd),
    .din   (rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign rx_byte   = rx_empty ? 8'h00 : rx_head;
  assign unused_rx = ^{rx_full, rx_count};
`else
  logic unused_rx;

  assign rx_byte   = 8'h00;
  assign unused_rx = ^{rx_data, rx_valid, rx_rd, RX_FIFO_DEPTH[0]};
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // NUL sends the terminating 0x00 straight to the UART, bypassing the FIFO.
  always_comb begin
    state_d  = state_q;
    tx_valid = !tx_empty;
    tx_data  = tx_empty ? 8'h00 : tx_head;
    case (state_q)
      ST_RUN:   if (stop_req) state_d = ST_DRAIN;
      ST_DRAIN: if (tx_empty) state_d = ST_NUL;
      ST_NUL: begin
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        if (tx_ready) state_d = ST_HALTED;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.mem_din        <= 8'h00;
      bus.io_buffer_full <= 1'b0;
      snapshot           <= '0;
      cycle_cnt          <= '0;
      tx_overflow        <= 1'b0;
    end else begin
      if (rd_en) bus.mem_din <= rd_byte;
      if (rd_en && (a == IO_CLK)) snapshot <= cycle_cnt;
      if (state_q != ST_HALTED) cycle_cnt <= cycle_cnt + 32'd1;
      if (tx_push && tx_full && !tx_pop_acc) tx_overflow <= 1'b1;
      bus.io_buffer_full <= (tx_count_nxt >= TX_CW'(TX_FIFO_DEPTH - 2));
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - self-checking bench for mem_io_responder (vectors, corner sequences, random vs model)
module tb_mem_io_responder;

  localparam int DEPTH = 8;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       halted;
  logic       tx_overflow;

  mem_io_responder_if bus ();

  mem_io_responder #(
    .RAM_ADDR_WIDTH (17),
    .TX_FIFO_DEPTH  (DEPTH),
    .RX_FIFO_DEPTH  (8)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .bus         (bus),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .halted      (halted),
    .tx_overflow (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0]   ram_m [0:131071];
  byte unsigned txq[$];
  byte unsigned sent[$];
`ifdef MEM_IO_RX_EN
  byte unsigned rxq[$];
`endif
  bit           m_stopped, m_drained, m_halted, m_ovf;
  logic [31:0]  m_cyc, m_snap;
  logic [7:0]   m_din;

  typedef struct {
    bit          wr;
    logic [17:0] a;
    logic [7:0]  d;
    bit          rdy;
    logic [7:0]  din;
    bit          valid;
    logic [7:0]  data;
  } vec_t;

  vec_t tbl[11];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_edge(bit wr, logic [17:0] a, logic [7:0] d, bit rdy);
    bit io, pre_stopped, pre_drained, pre_halted, pre_empty;
    io          = (a[17:16] == 2'b11);
    pre_stopped = m_stopped;
    pre_drained = m_drained;
    pre_halted  = m_halted;
    pre_empty   = (txq.size() == 0);
    if (!wr) begin
      if (!io) m_din = ram_m[a[16:0]];
      else if (a == 18'h30000) begin
        m_din = 8'h00;
`ifdef MEM_IO_RX_EN
        if (rxq.size() > 0) m_din = rxq.pop_front();
`endif
      end else if (a == 18'h30004) begin
        m_snap = m_cyc;
        m_din  = m_cyc[7:0];
      end else if (a >= 18'h30005 && a <= 18'h30007) m_din = 8'(m_snap >> (8 * (a - 18'h30004)));
      else m_din = 8'h00;
    end
`ifdef MEM_IO_RX_EN
    if (rx_valid && rxq.size() < 8) rxq.push_back(rx_data);
`endif
    if (rdy && !pre_empty) void'(txq.pop_front());
    if (wr && !pre_stopped) begin
      if (!io) ram_m[a[16:0]] = d;
      else if (a == 18'h30000 && d != 8'h00) begin
        if (txq.size() < DEPTH) txq.push_back(d);
        else m_ovf = 1'b1;
      end else if (a == 18'h30004) m_stopped = 1'b1;
    end
    if (pre_stopped && pre_empty) m_drained = 1'b1;
    if (pre_drained && rdy) m_halted = 1'b1;
    if (!pre_halted) m_cyc = m_cyc + 32'd1;
  endfunction

  task automatic step(input bit wr, input logic [17:0] a, input logic [7:0] d, input bit rdy);
    bit          nul;
    logic [7:0]  exp_data;
    bus.mem_wr   = wr;
    bus.mem_a    = {14'h0, a};
    bus.mem_dout = d;
    tx_ready     = rdy;
    if (tx_valid && rdy) sent.push_back(tx_data);
    model_edge(wr, a, d, rdy);
    @(posedge clk_in);
    #1;
    rx_valid = 1'b0;
    nul      = m_drained && !m_halted;
    exp_data = nul ? 8'h00 : (txq.size() > 0 ? txq[0] : 8'h00);
    check("model mem_din",        bus.mem_din, m_din);
    check("model tx_valid",       tx_valid, nul || txq.size() > 0);
    check("model tx_data",        tx_data, exp_data);
    check("model io_buffer_full", bus.io_buffer_full, txq.size() >= DEPTH - 2);
    check("model halted",         halted, m_halted);
    check("model tx_overflow",    tx_overflow, m_ovf);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 18'h3000C, 8'h00, rdy);
  endtask

  task automatic do_reset();
    rst_in       = 1'b1;
    bus.mem_wr   = 1'b0;
    bus.mem_a    = 32'h3000C;
    bus.mem_dout = 8'h00;
    tx_ready     = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in    = 1'b0;
    txq.delete();
    sent.delete();
`ifdef MEM_IO_RX_EN
    rxq.delete();
`endif
    m_stopped = 1'b0;
    m_drained = 1'b0;
    m_halted  = 1'b0;
    m_ovf     = 1'b0;
    m_cyc     = '0;
    m_snap    = '0;
    m_din     = 8'h00;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap_v;
    logic [7:0]  b [4];
    logic [7:0]  exp_b [4];
    logic [7:0]  c1;
    int          budget;

    for (int i = 0; i < 131072; i++) ram_m[i] = 8'h00;

    tbl[0]  = '{1'b1, 18'h00010, 8'hA5, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 18'h00010, 8'h00, 1'b1, 8'hA5, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 18'h30000, 8'h48, 1'b1, 8'hA5, 1'b1, 8'h48};
    tbl[3]  = '{1'b1, 18'h30000, 8'h00, 1'b1, 8'hA5, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 18'h30000, 8'h69, 1'b1, 8'hA5, 1'b1, 8'h69};
    tbl[5]  = '{1'b0, 18'h30008, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 18'h00010, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 18'h30001, 8'h77, 1'b0, 8'hA5, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 18'h30000, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 18'h20010, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 18'h00010, 8'h00, 1'b0, 8'h3C, 1'b0, 8'h00};

    // reset state
    do_reset();
    check("reset mem_din", bus.mem_din, 8'h00);
    check("reset io_buffer_full", bus.io_buffer_full, 1'b0);
    check("reset tx_valid", tx_valid, 1'b0);
    check("reset tx_data", tx_data, 8'h00);
    check("reset halted", halted, 1'b0);
    check("reset tx_overflow", tx_overflow, 1'b0);

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].rdy);
      check($sformatf("vec%0d mem_din", i), bus.mem_din, tbl[i].din);
      check($sformatf("vec%0d tx_valid", i), tx_valid, tbl[i].valid);
      check($sformatf("vec%0d tx_data", i), tx_data, tbl[i].data);
    end
    check("uart byte count", sent.size(), 2);
    if (sent.size() == 2) begin
      check("uart byte0", sent[0], 8'h48);
      check("uart byte1", sent[1], 8'h69);
    end

    // near-full flag, simultaneous push/pop at full, overflow
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 18'h30000, 8'(i), 1'b0);
      check($sformatf("ibf after push %0d", i), bus.io_buffer_full, i >= 6);
    end
    check("no overflow at full", tx_overflow, 1'b0);
    step(1'b1, 18'h30000, 8'd9, 1'b1);
    check("push+pop at full overflow", tx_overflow, 1'b0);
    check("push+pop at full head", tx_data, 8'd2);
    sent.delete();
    step(1'b1, 18'h30000, 8'd10, 1'b0);
    check("overflow sticky set", tx_overflow, 1'b1);
    budget = 0;
    while (tx_valid && budget < 20) begin
      idle(1'b1);
      budget++;
    end
    check("drain bounded", tx_valid, 1'b0);
    check("drain byte count", sent.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < sent.size()) check($sformatf("drain byte%0d", k), sent[k], 8'(k + 2));
    check("ibf after drain", bus.io_buffer_full, 1'b0);
    check("overflow still sticky", tx_overflow, 1'b1);

    // cycle counter snapshot
    do_reset();
    repeat (100) idle(1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 18'h30004 + 18'(k), 8'h00, 1'b0);
      b[k] = bus.mem_din;
    end
    snap_v = {b[3], b[2], b[1], b[0]};
    check("snapshot in 100..104", (snap_v >= 32'd100) && (snap_v <= 32'd104), 1'b1);

    // stop sequence
    do_reset();
    step(1'b1, 18'h00020, 8'h55, 1'b0);
    step(1'b1, 18'h30000, 8'h11, 1'b0);
    step(1'b1, 18'h30000, 8'h22, 1'b0);
    step(1'b1, 18'h30000, 8'h33, 1'b0);
    step(1'b1, 18'h30004, 8'hFF, 1'b0);
    check("stop: not halted yet", halted, 1'b0);
    check("stop: fifo still valid", tx_valid, 1'b1);
    step(1'b1, 18'h00020, 8'h99, 1'b0);
    step(1'b1, 18'h30000, 8'h44, 1'b0);
    sent.delete();
    budget = 0;
    while (!halted && budget < 20) begin
      idle(1'b1);
      budget++;
    end
    check("stop: halted", halted, 1'b1);
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h00};
    check("stop: byte count", sent.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < sent.size()) check($sformatf("stop byte%0d", k), sent[k], exp_b[k]);
    check("halted: tx_valid low", tx_valid, 1'b0);
    step(1'b0, 18'h00020, 8'h00, 1'b1);
    check("ram write ignored when stopping", bus.mem_din, 8'h55);
    step(1'b0, 18'h30004, 8'h00, 1'b1);
    c1 = bus.mem_din;
    repeat (5) idle(1'b1);
    step(1'b0, 18'h30004, 8'h00, 1'b1);
    check("counter frozen when halted", bus.mem_din, c1);

`ifdef MEM_IO_RX_EN
    do_reset();
    rx_data = 8'h31; rx_valid = 1'b1;
    idle(1'b0);
    rx_data = 8'h32; rx_valid = 1'b1;
    idle(1'b0);
    step(1'b0, 18'h30000, 8'h00, 1'b0);
    check("rx read 1", bus.mem_din, 8'h31);
    step(1'b0, 18'h30000, 8'h00, 1'b0);
    check("rx read 2", bus.mem_din, 8'h32);
    step(1'b0, 18'h30000, 8'h00, 1'b0);
    check("rx read empty", bus.mem_din, 8'h00);
`endif

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b1, 18'(i), 8'($urandom), 1'($urandom_range(0, 1)));
    for (int n = 0; n < 700; n++) begin
      int r;
      bit rdy;
      r   = $urandom_range(0, 99);
      rdy = ($urandom_range(0, 3) == 0);
`ifdef MEM_IO_RX_EN
      rx_valid = ($urandom_range(0, 4) == 0);
      rx_data  = 8'($urandom);
`endif
      if (r < 30)      step(1'b1, 18'($urandom_range(0, 63)), 8'($urandom), rdy);
      else if (r < 55) step(1'b0, 18'($urandom_range(0, 63)), 8'h00, rdy);
      else if (r < 80) step(1'b1, 18'h30000, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), rdy);
      else if (r < 95) step(1'b0, 18'h30000 + 18'($urandom_range(0, 8)), 8'h00, rdy);
      else if (r == 99 && n > 500) step(1'b1, 18'h30004, 8'($urandom), rdy);
      else idle(rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
